uart_rx_monitor: RTL and testbench

Simulation and FPGA receive monitor for the SoC serial console, sitting directly downstream of the core's `o_uart_tx` pin in the top-level simulation harness. It deserialises 8N1 frames and buffers completed bytes in a small FIFO. Bytes are presented on a valid/ready stream, so the harness can print them, compare them against expected output, or forward them to a host channel. It also reports framing errors and FIFO overflow as sticky flags.

---
 rtl/uart_mon_pkg.sv | 11 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_rx_monitor.sv | 107 ++++++++++
 tb/tb_uart_rx_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the serial console receive monitor.
package uart_mon_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; occupancy counter resolves full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 receive monitor: synchroniser, bit-timing FSM, byte FIFO and sticky error flags.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_500_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_overflow,
    input  logic                          i_clr_err,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int DIV  = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    logic [1:0]    sync;
    logic          rx_s;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick, push, full, empty, pop, stop_bad;

    assign rx_s     = sync[1];
    assign tick     = (cnt == '0);
    assign push     = (state == STOP) && tick && rx_s;
    assign stop_bad = (state == STOP) && tick && !rx_s;
    assign o_valid  = ~empty;
    assign pop      = o_valid & i_ready;
    assign o_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], i_rx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    cnt   <= HALF_M1;
                    state <= START;
                end
                START: if (tick) begin
                    if (rx_s) state <= IDLE;
                    else begin
                        cnt     <= DIV_M1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end else cnt <= cnt - 1'b1;
                DATA: if (tick) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    cnt     <= DIV_M1;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt - 1'b1;
                STOP: if (tick) state <= rx_s ? IDLE : BREAK;
                      else      cnt   <= cnt - 1'b1;
                // Hold off until the line idles so a long break is not read as frames.
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (stop_bad)       o_frame_err <= 1'b1;
            else if (i_clr_err) o_frame_err <= 1'b0;
            if (push && full && !pop) o_overflow <= 1'b1;
            else if (i_clr_err)       o_overflow <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (o_data),
        .full      (full),
        .empty     (empty),
        .count     (o_count)
    );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Random and directed frame stimulus against a queue-based model of the receive monitor.
module tb_uart_rx_monitor;
    localparam int DIV   = 109;
    localparam int DEPTH = 16;

    logic       clk = 1'b0, rst = 1'b1, i_rx = 1'b1, i_ready = 1'b0, i_clr_err = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overflow, o_busy;
    logic [4:0] o_count;

    int         checks = 0, errors = 0, rx_cnt = 0, ready_mode = 1;
    logic [7:0] mq[$];
    logic       exp_ferr = 1'b0, exp_ovf = 1'b0;

    uart_rx_monitor #(.CLK_FREQ_HZ(12_500_000), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overflow(o_overflow),
        .i_clr_err(i_clr_err), .o_busy(o_busy), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Consumer handshake: hold low, hold high, toggle, or random per cycle.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            2:       i_ready = ~i_ready;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Every accepted byte must be the oldest one the model expects.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            rx_cnt++;
            if (mq.size() == 0) chk("spurious_byte", {24'd0, o_data}, 32'hFFFF_FFFF);
            else                chk("data", {24'd0, o_data}, {24'd0, mq.pop_front()});
        end
    end

    // Frame at DIV clocks/bit; model is updated as the stop bit begins.
    task automatic send(input logic [7:0] d, input int stop_low = 0, input int abort_bit = -1);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                i_rx = fr[i];
                cycles(DIV / 2);
                return;
            end
            if (i == 9) begin
                if (stop_low > 0) begin
                    exp_ferr = 1'b1;
                    i_rx = 1'b0;
                    cycles(stop_low * DIV);
                    i_rx = 1'b1;
                    return;
                end
                if (mq.size() >= DEPTH) exp_ovf = 1'b1;
                else                    mq.push_back(d);
            end
            i_rx = fr[i];
            cycles(DIV);
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ferr"}, {31'd0, o_frame_err}, {31'd0, exp_ferr});
        chk({tag, "_ovf"},  {31'd0, o_overflow},  {31'd0, exp_ovf});
    endtask

    task automatic clr_flags();
        i_clr_err = 1'b1;
        cycles(1);
        i_clr_err = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((mq.size() != 0 || o_valid) && n < 3000) begin
            cycles(1);
            n++;
        end
        chk({tag, "_count"}, {27'd0, o_count}, 32'd0);
        chk({tag, "_left"}, mq.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        i_rx = 1'b1;
        cycles(3);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_count", {27'd0, o_count}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_data",  {24'd0, o_data}, 32'd0);
        chk("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
        chk("rst_ovf",   {31'd0, o_overflow}, 32'd0);
        mq.delete();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        rst = 1'b0;
        cycles(2);
    endtask

    initial begin
        int r0, good;
        logic [7:0] d;
        logic bad;

        do_reset();

        // Single byte, consumer always ready.
        r0 = rx_cnt;
        send(8'h55);
        cycles(20);
        drain("t1");
        chk("t1_bytes", rx_cnt - r0, 32'd1);
        check_flags("t1");

        // Short low pulse is rejected at the start-bit sample.
        i_rx = 1'b0;
        cycles(10);
        chk("t2_busy_mid", {31'd0, o_busy}, 32'd1);
        cycles(10);
        i_rx = 1'b1;
        cycles(38);
        chk("t2_busy_end", {31'd0, o_busy}, 32'd0);
        chk("t2_count", {27'd0, o_count}, 32'd0);
        cycles(DIV);

        // Low stop bit, then a clean frame.
        send(8'hA5, 2);
        cycles(2 * DIV);
        check_flags("t3");
        chk("t3_count", {27'd0, o_count}, 32'd0);
        clr_flags();
        check_flags("t3_clr");
        r0 = rx_cnt;
        send(8'h3C);
        cycles(20);
        drain("t3b");
        chk("t3_bytes", rx_cnt - r0, 32'd1);

        // Fill past depth with no consumer.
        ready_mode = 0;
        cycles(2);
        r0 = rx_cnt;
        for (int i = 0; i <= 16; i++) send(8'(i));
        cycles(20);
        chk("t4_count", {27'd0, o_count}, 32'd16);
        check_flags("t4");
        ready_mode = 1;
        drain("t4");
        chk("t4_bytes", rx_cnt - r0, 32'd16);
        clr_flags();
        check_flags("t4_clr");

        // Reset in the middle of a frame.
        send(8'h81, 0, 4);
        chk("t5_busy_pre", {31'd0, o_busy}, 32'd1);
        do_reset();
        cycles(2 * DIV);
        r0 = rx_cnt;
        send(8'h81);
        cycles(20);
        drain("t5");
        chk("t5_bytes", rx_cnt - r0, 32'd1);

        // Back-to-back frames with a toggling consumer.
        ready_mode = 2;
        r0 = rx_cnt;
        send(8'h0D);
        send(8'h0A);
        cycles(20);
        drain("t6");
        chk("t6_bytes", rx_cnt - r0, 32'd2);
        check_flags("t6");

        // Random bytes, gaps, consumer stalls and occasional bad stop bits.
        ready_mode = 3;
        r0 = rx_cnt;
        good = 0;
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send(d, bad ? 2 : 0);
            if (!bad) good++;
            cycles($urandom_range(0, 30) + (bad ? 10 : 0));
        end
        cycles(20);
        drain("t7");
        chk("t7_bytes", rx_cnt - r0, good);
        check_flags("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
